// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, counter
// states, default latencies and op-classification helpers.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate op codes).
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic {
    CTR_IDLE = 1'b0,
    CTR_RUN  = 1'b1
  } mdu_ctr_state_e;

  localparam int unsigned MDU_DEF_MUL_LAT = 5;
  localparam int unsigned MDU_DEF_DIV_LAT = 10;

  // Ops that occupy the unit for a latency window and write HI/LO at the end.
  function automatic logic mdu_is_long_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Divides use the divide latency; every other long op uses the multiply one.
  function automatic logic mdu_is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Any op the unit accepts at all.
  function automatic logic mdu_is_valid_op(input logic [3:0] op);
    return mdu_is_long_op(op) || (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/mdu_latency_ctr.sv
// Loadable down-counter that owns the IDLE/RUN state of the unit.
// busy is high while running; done pulses combinationally during the last
// busy cycle so the parent can write its result on the same edge busy drops.
module mdu_latency_ctr
  import mdu_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_count,
  output logic          o_busy,
  output logic          o_done
);

  mdu_ctr_state_e r_state;
  mdu_ctr_state_e w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;

  // State and counter register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= CTR_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: load in IDLE, count down in RUN, leave RUN as count hits zero
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_done      = 1'b0;
    case (r_state)
      CTR_IDLE: begin
        if (i_load) begin
          w_state_nxt = CTR_RUN;
          w_cnt_nxt   = i_count;
        end
      end
      CTR_RUN: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          o_done      = 1'b1;
          w_state_nxt = CTR_IDLE;
        end
      end
      default: begin
        w_state_nxt = CTR_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_busy = (r_state == CTR_RUN);

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Long ops latch their operands at acceptance, hold busy for a fixed latency
// and update HI/LO atomically on the edge busy drops. MTHI/MTLO write at once.
// Optional feature macro: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = MDU_DEF_MUL_LAT,
  parameter int unsigned DIV_LAT = MDU_DEF_DIV_LAT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             cancel,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);
  localparam int unsigned W2      = 2 * WIDTH;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  mdu_op_e          r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_long_acc;
  logic [CW-1:0]    w_lat;
  logic             w_done;

  assign w_accept   = start && !cancel && !busy && mdu_is_valid_op(op);
  assign w_long_acc = w_accept && mdu_is_long_op(op);
  assign w_lat      = mdu_is_div_op(op) ? CW'(DIV_LAT) : CW'(MUL_LAT);

  mdu_latency_ctr #(
    .CW(CW)
  ) u_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_long_acc),
    .i_count (w_lat),
    .o_busy  (busy),
    .o_done  (w_done)
  );

  // One shared multiplier; signedness only changes the operand extension.
  logic          w_mul_sgn;
  logic [W2-1:0] w_prod;

`ifdef MDU_MADD_EN
  assign w_mul_sgn = (r_op == OP_MULT) || (r_op == OP_MADD) || (r_op == OP_MSUB);
`else
  assign w_mul_sgn = (r_op == OP_MULT);
`endif
  assign w_prod = {{WIDTH{w_mul_sgn & r_a[WIDTH-1]}}, r_a} *
                  {{WIDTH{w_mul_sgn & r_b[WIDTH-1]}}, r_b};

  // Signed divide runs on magnitudes through the unsigned divider and fixes
  // signs afterwards. The most-negative / -1 case needs no special path:
  // the magnitude of MIN wraps to MIN, the quotient is MIN, remainder 0.
  logic             w_div_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_dvd;
  logic [WIDTH-1:0] w_dvs;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo_f;
  logic [WIDTH-1:0] w_rem_f;

  assign w_div_sgn = (r_op == OP_DIV);
  assign w_a_neg   = w_div_sgn & r_a[WIDTH-1];
  assign w_b_neg   = w_div_sgn & r_b[WIDTH-1];
  assign w_b_zero  = (r_b == '0);
  assign w_dvd     = w_a_neg ? -r_a : r_a;
  assign w_dvs     = w_b_zero ? WIDTH'(1) : (w_b_neg ? -r_b : r_b);
  assign w_quo     = w_dvd / w_dvs;
  assign w_rem     = w_dvd % w_dvs;
  assign w_quo_f   = (w_a_neg ^ w_b_neg) ? -w_quo : w_quo;
  assign w_rem_f   = w_a_neg ? -w_rem : w_rem;

  logic [W2-1:0] w_res;

  // Completion result {hi,lo} selected by the latched op
  always_comb begin
    w_res = {r_hi, r_lo};
    case (r_op)
      OP_MULT, OP_MULTU: w_res = w_prod;
      OP_DIV, OP_DIVU:   w_res = w_b_zero ? {r_a, {WIDTH{1'b1}}} : {w_rem_f, w_quo_f};
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: w_res = {r_hi, r_lo} + w_prod;
      OP_MSUB, OP_MSUBU: w_res = {r_hi, r_lo} - w_prod;
`endif
      default: ;
    endcase
  end

  // Operand latch, immediate MTHI/MTLO writes and completion write of HI/LO
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= OP_NONE;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_long_acc) begin
        r_a  <= a;
        r_b  <= b;
        r_op <= mdu_op_e'(op);
      end
      if (w_accept && (op == OP_MTHI)) r_hi <= a;
      if (w_accept && (op == OP_MTLO)) r_lo <= a;
      if (w_done) begin
        r_hi <= w_res[W2-1:WIDTH];
        r_lo <= w_res[WIDTH-1:0];
        r_op <= OP_NONE;
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes expected HI/LO and busy
// length for every accepted long op; a monitor pops them when busy falls.
module tb_mdu_unit;

  localparam int W       = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  localparam logic [3:0] C_MULT  = 4'd1;
  localparam logic [3:0] C_MULTU = 4'd2;
  localparam logic [3:0] C_DIV   = 4'd3;
  localparam logic [3:0] C_DIVU  = 4'd4;
  localparam logic [3:0] C_MTHI  = 4'd5;
  localparam logic [3:0] C_MTLO  = 4'd6;
  localparam logic [3:0] C_MADD  = 4'd7;
  localparam logic [3:0] C_MADDU = 4'd8;
  localparam logic [3:0] C_MSUB  = 4'd9;
  localparam logic [3:0] C_MSUBU = 4'd10;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic         start   = 1'b0;
  logic         cancel  = 1'b0;
  logic [3:0]   op      = '0;
  logic [W-1:0] a       = '0;
  logic [W-1:0] b       = '0;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mdu_unit #(
    .WIDTH   (W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .cancel  (cancel),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    string        name;
  } exp_t;

  exp_t sbq[$];

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  int           m_free_edge = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_long(input logic [3:0] o);
    if (o >= C_MULT && o <= C_DIVU) return 1'b1;
    if (MADD_EN && o >= C_MADD && o <= C_MSUBU) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int lat_of(input logic [3:0] o);
    return (o == C_DIV || o == C_DIVU) ? DIV_LAT : MUL_LAT;
  endfunction

  // Architectural result of an op from plain integer arithmetic
  function automatic logic [2*W-1:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic [2*W-1:0] acc);
    longint            sp;
    logic [2*W-1:0]    up;
    int                q;
    int                r;
    logic [W-1:0]      uq;
    logic [W-1:0]      ur;
    sp = longint'($signed(x)) * longint'($signed(y));
    up = {32'h0, x} * {32'h0, y};
    case (o)
      C_MULT:  return sp;
      C_MULTU: return up;
      C_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      C_DIVU: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        uq = x / y;
        ur = x % y;
        return {ur, uq};
      end
      C_MADD:  return acc + sp;
      C_MADDU: return acc + up;
      C_MSUB:  return acc - sp;
      C_MSUBU: return acc - up;
      default: return acc;
    endcase
  endfunction

  // Drive one request starting at a negedge; returns at the following negedge
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input string name);
    int   edge_n;
    bit   acc;
    bit   mbusy;
    exp_t e;
    start  = 1'b1;
    cancel = c;
    op     = o;
    a      = x;
    b      = y;
    edge_n = cyc + 1;
    acc = !c && (is_long(o) || o == C_MTHI || o == C_MTLO) && (edge_n > m_free_edge);
    if (acc) begin
      if (is_long(o)) begin
        {m_hi, m_lo} = model(o, x, y, {m_hi, m_lo});
        e.hi = m_hi; e.lo = m_lo; e.lat = lat_of(o); e.name = name;
        sbq.push_back(e);
        m_free_edge = edge_n + lat_of(o);
      end else if (o == C_MTHI) begin
        m_hi = x;
      end else begin
        m_lo = x;
      end
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 4'($urandom_range(0, 15));
    a      = $urandom;
    b      = $urandom;
    @(negedge clk);
    mbusy = (cyc + 1 <= m_free_edge);
    if (!mbusy) begin
      check({name, "_hi"}, hi, m_hi);
      check({name, "_lo"}, lo, m_lo);
      check({name, "_idle"}, W'(busy), '0);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("wait_idle_timeout", W'(busy), '0);
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) @(negedge clk);
    reset_n = 1'b1;
    sbq.delete();
    m_hi = '0;
    m_lo = '0;
    m_free_edge = 0;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: measure each busy window and compare HI/LO when it closes
  initial begin : monitor
    int   busy_cnt;
    logic prev_busy;
    exp_t e;
    busy_cnt  = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_cnt  = 0;
        prev_busy = 1'b0;
      end else begin
        if (busy) begin
          busy_cnt++;
        end else if (prev_busy) begin
          if (sbq.size() == 0) begin
            check("done_with_empty_scoreboard", W'(sbq.size()), 32'd1);
          end else begin
            e = sbq.pop_front();
            check({e.name, "_busy_cycles"}, W'(busy_cnt), W'(e.lat));
            check({e.name, "_sb_hi"}, hi, e.hi);
            check({e.name, "_sb_lo"}, lo, e.lo);
          end
          busy_cnt = 0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    logic [3:0] ro;
    @(negedge clk);
    do_reset(2);
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);
    check("reset_busy", W'(busy), '0);

    issue(C_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult_neg2x3");
    wait_idle();
    check("mult_neg2x3_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_neg2x3_lo_const", lo, 32'hFFFF_FFFA);

    issue(C_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
    wait_idle();
    check("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
    check("div_m7_2_hi_const", hi, 32'hFFFF_FFFF);

    issue(C_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0, "divu_m7_2");
    wait_idle();
    check("divu_lo_const", lo, 32'h7FFF_FFFC);
    check("divu_hi_const", hi, 32'h1);

    issue(C_DIV, 32'd5, 32'd0, 1'b0, "div_by_zero");
    wait_idle();
    check("div_by_zero_lo_const", lo, 32'hFFFF_FFFF);
    check("div_by_zero_hi_const", hi, 32'd5);

    issue(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    wait_idle();
    check("div_overflow_lo_const", lo, 32'h8000_0000);
    check("div_overflow_hi_const", hi, 32'h0);

    issue(C_MULT, 32'd7, 32'd9, 1'b1, "mult_cancel");
    issue(4'd13, 32'd1, 32'd1, 1'b0, "invalid_op");
    issue(C_MADD, 32'd2, 32'd2, 1'b0, "madd_code");
    wait_idle();

    issue(C_MULT, 32'd100, 32'd200, 1'b0, "mult_then_mtlo");
    issue(C_MTLO, 32'h1234, 32'd0, 1'b0, "mtlo_while_busy");
    wait_idle();
    check("mtlo_ignored_lo_const", lo, 32'd20000);

    issue(C_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0, "mthi");
    issue(C_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0, "mtlo");

    issue(C_DIVU, 32'd1000, 32'd7, 1'b0, "divu_reset");
    repeat (3) @(negedge clk);
    do_reset(2);
    check("midop_reset_hi", hi, '0);
    check("midop_reset_lo", lo, '0);
    check("midop_reset_busy", W'(busy), '0);
    repeat (15) @(negedge clk);
    check("midop_later_hi", hi, '0);
    check("midop_later_lo", lo, '0);
    check("midop_later_busy", W'(busy), '0);

`ifdef MDU_MADD_EN
    issue(C_MTHI, 32'd0, 32'd0, 1'b0, "mthi0");
    issue(C_MTLO, 32'd10, 32'd0, 1'b0, "mtlo10");
    issue(C_MADD, 32'd3, 32'd4, 1'b0, "madd_3x4");
    wait_idle();
    check("madd_lo_const", lo, 32'd22);
    check("madd_hi_const", hi, 32'd0);
    issue(C_MSUBU, 32'd1, 32'd23, 1'b0, "msubu_1x23");
    wait_idle();
    check("msubu_lo_const", lo, 32'hFFFF_FFFF);
    check("msubu_hi_const", hi, 32'hFFFF_FFFF);
`else
    issue(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    wait_idle();
    issue(C_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_b2b_min");
    wait_idle();
    check("mult_min_hi_const", hi, 32'h4000_0000);
    check("mult_min_lo_const", lo, 32'h0);
`endif

    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      issue(ro, rnd_operand(), rnd_operand(), ($urandom_range(0, 7) == 0), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0)
        issue(4'($urandom_range(1, 10)), $urandom, $urandom, 1'b0, $sformatf("rnd%0d_extra", i));
      wait_idle();
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", W'(sbq.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
